// File: rtl/bcd_seg_pkg.sv
// Shared definitions for the BCD seven-segment scanner.
// Holds the scanner state encoding, the active-low segment patterns
// (segments [6:0] = g..a) and the double-dabble digit adjust helper.
package bcd_seg_pkg;

    // Scanner state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CONV = 2'd1;
    localparam state_t ST_SHOW = 2'd2;

    // Active-low segment patterns, bit order g..a
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Double-dabble correction applied to a BCD digit before each shift
    function automatic logic [3:0] dd_adjust(input logic [3:0] digit);
        return (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to seven-segment decoder.
// Ports:
//   bcd_i [3:0] : BCD digit 0..9
//   seg_o [6:0] : active-low segments g..a; non-BCD codes give a blank digit
module seg7_decoder
    import bcd_seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Eight-word BCD seven-segment scanner.
// On start (in idle) the eight 7-bit words are snapshotted; each word is then
// converted to BCD by a 7-cycle sequential double-dabble and presented for
// HOLD_CYCLES cycles. A frame therefore lasts 8*(7+HOLD_CYCLES) cycles.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : frame request, sampled only while idle
//   data0..data7 [6:0]  : words to display
//   busy                : frame in progress
//   digit_valid         : digit_idx/tens_seg/ones_seg/overflow carry a result
//   digit_idx [2:0]     : index of the word being presented
//   tens_seg, ones_seg  : active-low segments g..a
//   overflow            : presented word above 99 (both digits show a dash)
//   done                : one-cycle pulse in the first idle cycle after a frame
module bcd_seg_scanner
    import bcd_seg_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] data0,
    input  logic [6:0] data1,
    input  logic [6:0] data2,
    input  logic [6:0] data3,
    input  logic [6:0] data4,
    input  logic [6:0] data5,
    input  logic [6:0] data6,
    input  logic [6:0] data7,
    output logic       busy,
    output logic       digit_valid,
    output logic [2:0] digit_idx,
    output logic [6:0] tens_seg,
    output logic [6:0] ones_seg,
    output logic       overflow,
    output logic       done
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [6:0]       bin_q, bin_d;
    logic [11:0]      bcd_q, bcd_d;     // {hundreds, tens, ones}
    logic [6:0]       snap_q [8];
    logic [6:0]       snap_d [8];

    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [6:0]       tens_q, tens_d;
    logic [6:0]       ones_q, ones_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [6:0]       tens_dec, ones_dec;

    // Next-state: FSM, snapshot and sequential double-dabble
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        snap_d     = snap_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d[0] = data0;
                    snap_d[1] = data1;
                    snap_d[2] = data2;
                    snap_d[3] = data3;
                    snap_d[4] = data4;
                    snap_d[5] = data5;
                    snap_d[6] = data6;
                    snap_d[7] = data7;
                    idx_d     = 3'd0;
                    // Snapshot array is written this edge, so load from the port
                    bin_d     = data0;
                    bcd_d     = '0;
                    bit_cnt_d = 3'd0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                // Hundreds never reaches 5 for a 7-bit word, so it only shifts
                bcd_d = {bcd_q[10:8], dd_adjust(bcd_q[7:4]), dd_adjust(bcd_q[3:0]),
                         bin_q[6]};
                bin_d = {bin_q[5:0], 1'b0};
                if (bit_cnt_q == 3'd6) begin
                    hold_cnt_d = '0;
                    state_d    = ST_SHOW;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            ST_SHOW: begin
                if (hold_cnt_q == HoldLast) begin
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        bin_d     = snap_q[idx_q + 3'd1];
                        bcd_d     = '0;
                        bit_cnt_d = 3'd0;
                        state_d   = ST_CONV;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decoders look at next-state BCD so the segment registers load together
    // with the transition into SHOW.
    seg7_decoder u_tens_dec (
        .bcd_i (bcd_d[7:4]),
        .seg_o (tens_dec)
    );

    seg7_decoder u_ones_dec (
        .bcd_i (bcd_d[3:0]),
        .seg_o (ones_dec)
    );

    // Registered output next-state
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_SHOW);
        ovf_d   = valid_d && (bcd_d[11:8] != 4'd0);
        tens_d  = SEG_BLANK;
        ones_d  = SEG_BLANK;
        if (valid_d) begin
            if (ovf_d) begin
                tens_d = SEG_DASH;
                ones_d = SEG_DASH;
            end else begin
                // Leading-zero blanking for single-digit values
                tens_d = (bcd_d[7:4] == 4'd0) ? SEG_BLANK : tens_dec;
                ones_d = ones_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            bit_cnt_q  <= 3'd0;
            hold_cnt_q <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            for (int i = 0; i < 8; i++) begin
                snap_q[i] <= '0;
            end
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            tens_q     <= SEG_BLANK;
            ones_q     <= SEG_BLANK;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            snap_q     <= snap_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign busy        = busy_q;
    assign digit_valid = valid_q;
    assign digit_idx   = idx_q;
    assign tens_seg    = tens_q;
    assign ones_seg    = ones_q;
    assign overflow    = ovf_q;
    assign done        = done_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed self-checking bench for bcd_seg_scanner (HOLD_CYCLES = 4).
// Each frame is walked cycle by cycle against hand-written expected segments.
module tb_bcd_seg_scanner;

    localparam int PERIOD   = 11;          // 7 conversion + 4 hold cycles
    localparam int CONV_LEN = 7;
    localparam int FRAME    = 8 * PERIOD;  // 88

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DA = 7'b0111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;

    typedef logic [6:0] word8_t [8];

    logic       clk;
    logic       reset;
    logic       start;
    logic [6:0] data [8];
    logic       busy;
    logic       digit_valid;
    logic [2:0] digit_idx;
    logic [6:0] tens_seg;
    logic [6:0] ones_seg;
    logic       overflow;
    logic       done;

    int tests = 0;
    int fails = 0;

    bcd_seg_scanner #(
        .HOLD_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data0       (data[0]),
        .data1       (data[1]),
        .data2       (data[2]),
        .data3       (data[3]),
        .data4       (data[4]),
        .data5       (data[5]),
        .data6       (data[6]),
        .data7       (data[7]),
        .busy        (busy),
        .digit_valid (digit_valid),
        .digit_idx   (digit_idx),
        .tens_seg    (tens_seg),
        .ones_seg    (ones_seg),
        .overflow    (overflow),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input word8_t v);
        for (int i = 0; i < 8; i++) data[i] = v[i];
    endtask

    // Starts a frame from idle and checks every cycle of it, ending in the done
    // cycle. poke: busy cycle at which data is scrambled and start pulsed.
    task automatic run_frame(input string name, input word8_t et, input word8_t eo,
                             input logic [7:0] ev, input int poke, input bit keep_start);
        start = 1'b1;
        tick();
        if (!keep_start) start = 1'b0;
        for (int c = 1; c <= FRAME; c++) begin
            int w;
            int p;
            w = (c - 1) / PERIOD;
            p = (c - 1) % PERIOD;
            check($sformatf("%s c%0d busy", name, c), 32'(busy), 32'd1);
            check($sformatf("%s c%0d valid", name, c), 32'(digit_valid),
                  32'(p >= CONV_LEN));
            check($sformatf("%s c%0d done", name, c), 32'(done), 32'd0);
            if (p >= CONV_LEN) begin
                check($sformatf("%s c%0d idx", name, c), 32'(digit_idx), 32'(w));
                check($sformatf("%s c%0d tens", name, c), 32'(tens_seg), 32'(et[w]));
                check($sformatf("%s c%0d ones", name, c), 32'(ones_seg), 32'(eo[w]));
                check($sformatf("%s c%0d ovf", name, c), 32'(overflow), 32'(ev[w]));
            end else begin
                check($sformatf("%s c%0d tens_blank", name, c), 32'(tens_seg), 32'(BL));
                check($sformatf("%s c%0d ones_blank", name, c), 32'(ones_seg), 32'(BL));
                check($sformatf("%s c%0d ovf_low", name, c), 32'(overflow), 32'd0);
            end
            if (c == poke) begin
                for (int i = 0; i < 8; i++) data[i] = 7'(99 - i);
                start = 1'b1;
            end else if (c == poke + 1 && !keep_start) begin
                start = 1'b0;
            end
            tick();
        end
        check({name, " end done"}, 32'(done), 32'd1);
        check({name, " end busy"}, 32'(busy), 32'd0);
        check({name, " end valid"}, 32'(digit_valid), 32'd0);
        check({name, " end tens"}, 32'(tens_seg), 32'(BL));
        check({name, " end ones"}, 32'(ones_seg), 32'(BL));
    endtask

    task automatic check_idle_after(input string name);
        tick();
        check({name, " post done"}, 32'(done), 32'd0);
        check({name, " post busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        word8_t vec_a;
        word8_t vec_b;
        word8_t a_tens;
        word8_t a_ones;
        word8_t b_tens;
        word8_t b_ones;
        logic [7:0] a_ovf;
        logic [7:0] b_ovf;

        vec_a  = '{7'd1, 7'd2, 7'd5, 7'd15, 7'd35, 7'd50, 7'd75, 7'd100};
        a_tens = '{BL, BL, BL, S1, S3, S5, S7, DA};
        a_ones = '{S1, S2, S5, S5, S5, S0, S5, DA};
        a_ovf  = 8'b1000_0000;

        vec_b  = '{7'd0, 7'd9, 7'd10, 7'd99, 7'd127, 7'd42, 7'd63, 7'd88};
        b_tens = '{BL, BL, S1, S9, DA, S4, S6, S8};
        b_ones = '{S0, S9, S0, S9, DA, S2, S3, S8};
        b_ovf  = 8'b0001_0000;

        // Reset held two cycles
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) data[i] = '0;
        tick();
        tick();
        check("rst busy", 32'(busy), 32'd0);
        check("rst valid", 32'(digit_valid), 32'd0);
        check("rst idx", 32'(digit_idx), 32'd0);
        check("rst tens", 32'(tens_seg), 32'(BL));
        check("rst ones", 32'(ones_seg), 32'(BL));
        check("rst ovf", 32'(overflow), 32'd0);
        check("rst done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        check("idle busy", 32'(busy), 32'd0);

        // Mixed values including overflow
        set_data(vec_a);
        run_frame("A", a_tens, a_ones, a_ovf, -1, 1'b0);
        check_idle_after("A");

        // Boundary values
        set_data(vec_b);
        run_frame("B", b_tens, b_ones, b_ovf, -1, 1'b0);
        check_idle_after("B");

        // Data change and start pulse during idx2 SHOW must not disturb the frame
        set_data(vec_a);
        run_frame("POKE", a_tens, a_ones, a_ovf, 2 * PERIOD + CONV_LEN + 1, 1'b0);
        check_idle_after("POKE");

        // Reset (with start also high) in the middle of idx4 conversion
        set_data(vec_b);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 4 * PERIOD + 3; i++) tick();
        check("pre-rst busy", 32'(busy), 32'd1);
        check("pre-rst valid", 32'(digit_valid), 32'd0);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst valid", 32'(digit_valid), 32'd0);
        check("midrst tens", 32'(tens_seg), 32'(BL));
        check("midrst ones", 32'(ones_seg), 32'(BL));
        check("midrst ovf", 32'(overflow), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst idx", 32'(digit_idx), 32'd0);
        tick();
        tick();
        check("midrst still idle", 32'(busy), 32'd0);
        set_data(vec_a);
        run_frame("AFTER-RST", a_tens, a_ones, a_ovf, -1, 1'b0);
        check_idle_after("AFTER-RST");

        // start held high: back-to-back frames with a single idle/done cycle
        set_data(vec_b);
        run_frame("B2B-1", b_tens, b_ones, b_ovf, -1, 1'b1);
        run_frame("B2B-2", b_tens, b_ones, b_ovf, -1, 1'b0);
        check_idle_after("B2B-2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
